// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the HI/LO multiply-divide issue controller:
//   MD op codes as carried on ex_op / md_sel, default unit latencies,
//   controller state type and op-class decode helpers.
// ---------------------------------------------------------------------------
package md_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;

   localparam int unsigned MUL_LAT = 5;
   localparam int unsigned DIV_LAT = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // mult/multu/div/divu: ops that occupy the unit for a latency window
   function automatic logic is_mdiv(input logic [3:0] op);
      return (op >= MD_MULT) && (op <= MD_DIVU);
   endfunction

   // ops that need a start strobe to the unit (timed ops plus HI/LO writes)
   function automatic logic is_md(input logic [3:0] op);
      return is_mdiv(op) || (op == MD_MTHI) || (op == MD_MTLO);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// ---------------------------------------------------------------------------
// md_lat_cnt
//   Down-counter mirroring the multiply-divide unit's busy window.
//   Ports:
//     clk     in  rising-edge clock
//     reset   in  asynchronous, active-low reset
//     ld      in  load strobe (takes priority over decrement)
//     ld_val  in  value loaded on ld
//     dec     in  decrement by one (saturates at zero)
//     cnt     out current count
//     zero    out cnt == 0
// ---------------------------------------------------------------------------
module md_lat_cnt #(
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld,
   input  logic [CW-1:0] ld_val,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//   EX-stage issue/hazard controller in front of the HI/LO multiply-divide
//   unit. Decodes the EX op, drives the unit's start/sel/operand/enable,
//   tracks the unit's busy window with a latency counter and stalls IF/ID
//   while an MD-class instruction in ID would collide with a running op.
//
//   Optional feature: define MD_DIV0_GUARD_EN to block div/divu with a zero
//   divisor and report it with a one-cycle div0 pulse. Undefined: div0 = 0.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-low reset
//     id_md_use  in   ID instr is mult/div/mfhi/mflo/mthi/mtlo
//     ex_valid   in   EX slot holds a live instruction
//     ex_op      in   EX MD op code (md_pkg MD_*)
//     ex_a/ex_b  in   forwarded rs/rt values
//     ex_flush   in   exception/interrupt kills the EX instr this cycle
//     md_start   out  start strobe to MD unit
//     md_clr     out  issue enable to MD unit (0 = killed)
//     md_sel     out  op code to MD unit (0 when EX empty)
//     md_a/md_b  out  operands to MD unit
//     stall      out  freeze PC and IF/ID, bubble into ID/EX
//     md_busy    out  registered busy (count != 0)
//     div0       out  divide-by-zero pulse (guard build only)
// ---------------------------------------------------------------------------
module md_issue_ctrl #(
   parameter int unsigned W       = 32,
   parameter int unsigned MUL_LAT = md_pkg::MUL_LAT,
   parameter int unsigned DIV_LAT = md_pkg::DIV_LAT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         id_md_use,
   input  logic         ex_valid,
   input  logic [3:0]   ex_op,
   input  logic [W-1:0] ex_a,
   input  logic [W-1:0] ex_b,
   input  logic         ex_flush,
   output logic         md_start,
   output logic         md_clr,
   output logic [3:0]   md_sel,
   output logic [W-1:0] md_a,
   output logic [W-1:0] md_b,
   output logic         stall,
   output logic         md_busy,
   output logic         div0
);

   import md_pkg::*;

   localparam int unsigned CW = $clog2(DIV_LAT + 1);

   md_state_t     state, state_nxt;
   logic [CW-1:0] cnt;
   logic          cnt_zero;
   logic          ex_mdiv;
   logic          div0_blk;
   logic          issue_ld;
   logic [CW-1:0] ld_val;

   // zero-divisor block: a guarded div never reaches the unit
`ifdef MD_DIV0_GUARD_EN
   assign div0_blk = ex_valid & is_div(ex_op) & (ex_b == '0);
`else
   assign div0_blk = 1'b0;
`endif

   assign ex_mdiv  = ex_valid & is_mdiv(ex_op);
   assign issue_ld = ex_mdiv & ~ex_flush & ~div0_blk & (state == ST_IDLE);
   assign ld_val   = is_div(ex_op) ? CW'(DIV_LAT) : CW'(MUL_LAT);

   md_lat_cnt #(
      .CW (CW)
   ) u_lat_cnt (
      .clk    (clk),
      .reset  (reset),
      .ld     (issue_ld),
      .ld_val (ld_val),
      .dec    (state == ST_RUN),
      .cnt    (cnt),
      .zero   (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // leave RUN on the edge where the unit commits HI/LO (cnt == 1)
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (issue_ld) state_nxt = ST_RUN;
         ST_RUN:  if (cnt == CW'(1)) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign md_start = ex_valid & is_md(ex_op) & ~div0_blk;
   assign md_clr   = ~ex_flush;
   assign md_sel   = ex_valid ? ex_op : MD_NONE;
   assign md_a     = ex_a;
   assign md_b     = ex_b;
   assign md_busy  = ~cnt_zero;

   // the EX term covers the unit's combinational busy in the start cycle
   assign stall = id_md_use & ((state == ST_RUN) | (ex_mdiv & ~ex_flush));

`ifdef MD_DIV0_GUARD_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div0 <= 1'b0;
      end else begin
         div0 <= div0_blk & ~ex_flush;
      end
   end
`else
   assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl
//   Self-checking bench for md_issue_ctrl. The reference model records the
//   cycle index at which the unit's busy window ends and derives busy/stall
//   from plain cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_md_use;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic        ex_flush;
   logic        md_start;
   logic        md_clr;
   logic [3:0]  md_sel;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        stall;
   logic        md_busy;
   logic        div0;

   int total = 0;
   int bad   = 0;

   // reference model state
   int cyc      = 0;
   int busy_end = -1;   // last cycle index in which md_busy is high
   bit div0_exp = 1'b0;

`ifdef MD_DIV0_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   md_issue_ctrl #(
      .W       (32),
      .MUL_LAT (5),
      .DIV_LAT (10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .id_md_use (id_md_use),
      .ex_valid  (ex_valid),
      .ex_op     (ex_op),
      .ex_a      (ex_a),
      .ex_b      (ex_b),
      .ex_flush  (ex_flush),
      .md_start  (md_start),
      .md_clr    (md_clr),
      .md_sel    (md_sel),
      .md_a      (md_a),
      .md_b      (md_b),
      .stall     (stall),
      .md_busy   (md_busy),
      .div0      (div0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic drive(input bit v, input int op, input logic [31:0] a,
                        input logic [31:0] b, input bit fl, input bit idu);
      ex_valid  = v;
      ex_op     = 4'(op);
      ex_a      = a;
      ex_b      = b;
      ex_flush  = fl;
      id_md_use = idu;
   endtask

   // expected values from the op table
   function automatic bit op_timed(input int op);
      return op >= 1 && op <= 4;
   endfunction

   function automatic bit blocked_div0();
      return GUARD && ex_valid && (ex_op == 3 || ex_op == 4) && ex_b == 0;
   endfunction

   function automatic bit model_busy();
      return reset && (cyc <= busy_end);
   endfunction

   // check current cycle, then advance the model across the next edge
   task automatic step();
      bit busy_e, start_e, stall_e, issue;
      #2;
      if (!reset) begin
         busy_end = -1;
         div0_exp = 1'b0;
      end
      busy_e  = model_busy();
      start_e = ex_valid && (op_timed(ex_op) || ex_op == 7 || ex_op == 8) && !blocked_div0();
      stall_e = id_md_use && (busy_e || (ex_valid && op_timed(ex_op) && !ex_flush));
      chk("md_busy",  32'(md_busy),  32'(busy_e));
      chk("stall",    32'(stall),    32'(stall_e));
      chk("md_start", 32'(md_start), 32'(start_e));
      chk("md_clr",   32'(md_clr),   32'(!ex_flush));
      chk("md_sel",   32'(md_sel),   ex_valid ? 32'(ex_op) : 32'd0);
      chk("md_a",     md_a,          ex_a);
      chk("md_b",     md_b,          ex_b);
      chk("div0",     32'(div0),     32'(div0_exp));
      issue = reset && ex_valid && op_timed(ex_op) && !ex_flush && !busy_e && !blocked_div0();
      @(posedge clk);
      if (reset) begin
         if (issue) busy_end = cyc + ((ex_op >= 3) ? 10 : 5);
         div0_exp = blocked_div0() && !ex_flush;
      end
      cyc++;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      // combinational outputs follow inputs while reset is held
      drive(1, 1, 32'd3, 32'hFFFF_FFFC, 0, 1);
      step();
      step();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      step();

      // mult 3,-4 with mfhi waiting in ID
      drive(1, 1, 32'd3, 32'hFFFF_FFFC, 0, 1);
      step();
      drive(0, 0, 0, 0, 0, 1);
      repeat (7) step();

      // divu 100,7 with ID waiting
      drive(1, 4, 32'd100, 32'd7, 0, 1);
      step();
      drive(0, 0, 0, 0, 0, 1);
      repeat (12) step();

      // flushed mult must not start a busy window
      drive(1, 1, 32'd9, 32'd9, 1, 1);
      step();
      drive(0, 0, 0, 0, 0, 1);
      repeat (2) step();

      // div running, async reset at cnt == 6
      drive(1, 3, 32'd50, 32'd3, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 1);
      repeat (4) step();
      #2 reset = 1'b0;
      #1;
      chk("rst_busy",  32'(md_busy), 32'd0);
      chk("rst_stall", 32'(stall),   32'd0);
      @(posedge clk);
      cyc++;
      busy_end = -1;
      div0_exp = 1'b0;
      #1;
      step();
      reset = 1'b1;
      step();

      // mthi in EX while idle, then mfhi in ID
      drive(1, 7, 32'h1234, 32'd0, 0, 0);
      step();
      drive(1, 5, 32'd0, 32'd0, 0, 1);
      step();

      // divide by zero
      drive(1, 3, 32'd5, 32'd0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      repeat (12) step();

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 4) != 0,
               int'($urandom_range(0, 9)),
               $urandom,
               (($urandom % 8) == 0) ? 32'd0 : $urandom,
               ($urandom % 6) == 0,
               ($urandom % 2) == 0);
         reset = (($urandom % 250) != 0);
         step();
      end
      reset = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
